// File: rtl/fetch_pipe_controller.sv
// fetch_pipe_controller: sequences main-pipe flush requests through optional
// I-cache / I-TLB invalidation, broadcasts a one-cycle flush with the redirect
// PC to the fetch stages, and merges the stage stall requests.
module fetch_pipe_controller #(
   parameter int VADDR_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rstN,
   input  logic                   flushFromMainPipe,
   input  logic [1:0]             flushReason,
   input  logic [VADDR_WIDTH-1:0] flushTargetPcFromMainPipe,
   input  logic                   stallFromICacheReadStage,
   input  logic                   stallFromInsnTraverseStage,
   input  logic                   invalidateICacheDone,
   input  logic                   invalidateITlbDone,
   output logic                   stall,
   output logic                   flush,
   output logic [VADDR_WIDTH-1:0] flushTargetPc,
   output logic                   invalidateICache,
   output logic                   invalidateITlb
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_INV_IC  = 2'd1,
      S_INV_TLB = 2'd2,
      S_FLUSH   = 2'd3
   } state_t;

   localparam logic [1:0] RSN_FENCEI  = 2'd1;
   localparam logic [1:0] RSN_SFENCE  = 2'd2;

   state_t                 state_q;
   logic                   flush_q;
   logic                   inv_ic_q;
   logic                   inv_tlb_q;
   logic [VADDR_WIDTH-1:0] pc_q;
   logic                   inv_wait;

   // Flush FSM with registered outputs; Idle and Flush both accept requests so
   // back-to-back flushes need no bubble.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q   <= S_IDLE;
         flush_q   <= 1'b0;
         inv_ic_q  <= 1'b0;
         inv_tlb_q <= 1'b0;
         pc_q      <= '0;
      end else begin
         flush_q <= 1'b0;
         case (state_q)
            S_IDLE, S_FLUSH: begin
               if (flushFromMainPipe) begin
                  pc_q <= flushTargetPcFromMainPipe;
                  case (flushReason)
                     RSN_FENCEI: begin
                        state_q  <= S_INV_IC;
                        inv_ic_q <= 1'b1;
                     end
                     RSN_SFENCE: begin
                        state_q   <= S_INV_TLB;
                        inv_tlb_q <= 1'b1;
                     end
                     default: begin
                        // Normal and the reserved encoding redirect only.
                        state_q <= S_FLUSH;
                        flush_q <= 1'b1;
                     end
                  endcase
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_INV_IC: begin
               if (invalidateICacheDone) begin
                  state_q  <= S_FLUSH;
                  flush_q  <= 1'b1;
                  inv_ic_q <= 1'b0;
               end
            end
            S_INV_TLB: begin
               if (invalidateITlbDone) begin
                  state_q   <= S_FLUSH;
                  flush_q   <= 1'b1;
                  inv_tlb_q <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Stages stay frozen for the whole invalidation window; flush wins over stall.
   always_comb begin
      inv_wait = (state_q == S_INV_IC) || (state_q == S_INV_TLB);
      stall    = !flush_q && (stallFromICacheReadStage || stallFromInsnTraverseStage || inv_wait);
   end

   assign flush            = flush_q;
   assign flushTargetPc    = pc_q;
   assign invalidateICache = inv_ic_q;
   assign invalidateITlb   = inv_tlb_q;

endmodule
